// File: rtl/arb4_rr.sv
// arb4_rr: four-requester round-robin arbiter with owner release and an optional hold-time limit.
// Registered one-hot and binary grant; priority rotates from the last owner.
module arb4_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     r_state, w_state_nxt;
    logic [1:0] r_last_idx, w_last_nxt, w_win;
    logic [7:0] r_hold_cnt, w_hold_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_idx_nxt;
    logic       w_valid_nxt, w_timeout_nxt, w_limit, w_drop;
    assign w_limit = (MAX_HOLD != 0) && (r_hold_cnt == 8'(MAX_HOLD - 1));
    assign w_drop  = !en || rel || !req[gnt_idx];
    // Descending scan so the nearest requester after last_idx is assigned last and wins
    always_comb begin
        w_win = r_last_idx;
        for (int k = 4; k >= 1; k--)
            if (req[r_last_idx + 2'(k)]) w_win = r_last_idx + 2'(k);
    end
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last_idx;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = gnt;
        w_idx_nxt     = gnt_idx;
        w_valid_nxt   = gnt_valid;
        w_timeout_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (en && |req) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = 4'b0001 << w_win;
                w_idx_nxt   = w_win;
                w_valid_nxt = 1'b1;
                w_last_nxt  = w_win;
                w_hold_nxt  = 8'd0;
            end
        end else if (w_drop || w_limit) begin
            w_state_nxt   = IDLE;
            w_gnt_nxt     = 4'b0000;
            w_idx_nxt     = 2'd0;
            w_valid_nxt   = 1'b0;
            w_timeout_nxt = !w_drop;
        end else begin
            w_hold_nxt = (r_hold_cnt == 8'hff) ? r_hold_cnt : r_hold_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_idx <= 2'd3;
            r_hold_cnt <= 8'd0;
            gnt        <= 4'b0000;
            gnt_idx    <= 2'd0;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_idx <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
            gnt        <= w_gnt_nxt;
            gnt_idx    <= w_idx_nxt;
            gnt_valid  <= w_valid_nxt;
            timeout    <= w_timeout_nxt;
        end
    end
endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter that shares a single downstream resource on the npc datapath, such as a memory port or a shared functional unit. It samples a 4-bit request vector and issues one registered grant, both one-hot and binary-encoded. It holds that grant until the owner releases it or a hold-time limit expires, then rotates priority so that no requester starves.

## Interface
- `MAX_HOLD`, default 16: maximum cycles one grant may stay asserted before forced revocation. 0 disables the limit. Legal range 0..255.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: arbiter enable. While low, no grant is issued and any held grant is revoked.
- `req` input 4: request vector; bit i is high while requester i wants the resource.
- `rel` input 1: release strobe from the current owner; ignored when no grant is held.
- `gnt` output 4: one-hot grant; all zeros when idle.
- `gnt_idx` output 2: binary index of the granted requester; 0 when idle.
- `gnt_valid` output 1: high while a grant is held; equals `|gnt`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- All outputs are registered.
- Reset values:
  - outputs: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0
  - internal: state IDLE, `last_idx`=3, `hold_cnt`=0
- Consequence of `last_idx`=3: requester 0 has top priority after reset.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - Stays in IDLE if `en`=0 or `req`==0.
  - Otherwise it selects a winner. The search starts at (`last_idx`+1) mod 4 and wraps ascending; the first set `req` bit wins.
  - On the clock edge it loads `gnt`/`gnt_idx`, sets `last_idx` to the winner, clears `hold_cnt`, and moves to GRANT.
- GRANT exits to IDLE on the next edge when any of these hold, checked in this priority order:
  1. `en`=0 (revoke, `timeout`=0);
  2. `rel`=1 (release, `timeout`=0);
  3. `req[gnt_idx]`=0 (owner dropped request, `timeout`=0);
  4. `MAX_HOLD`!=0 and `hold_cnt`==`MAX_HOLD`-1 (forced revoke, `timeout`=1 for exactly one cycle).
- When none of those conditions hold, `hold_cnt` increments and saturates at 255.
- On every exit `gnt`, `gnt_idx` and `gnt_valid` return to 0. `last_idx` is kept, so rotation continues from the previous owner.
- Simultaneous exit conditions: `rel` together with the hold limit counts as a release, so no `timeout` pulse is generated.
- Requests from non-owners during GRANT are ignored. They are served from the next IDLE cycle.
- A single requester re-requesting is granted again after one IDLE cycle. Rotation does not block it when it is the only requester.
- Asserting `rst_n` mid-grant forces reset values immediately, without waiting for a clock edge.

## Timing
- Grant latency:
  - `req` seen in IDLE on edge t gives `gnt` valid in the cycle after edge t.
  - Minimum request-to-grant: 1 cycle.
- Release latency: `rel` high before edge t gives `gnt`=0 after edge t.
- Dead time: IDLE always lasts at least one cycle between grants, so the earliest next grant appears after edge t+1.
- Maximum grant length is `MAX_HOLD` cycles: `hold_cnt` counts 0..`MAX_HOLD`-1, and the revoke takes effect on the following edge.
- `timeout` is high in the single cycle after the forced-revoke edge, concurrent with IDLE.
- Worst-case wait with all four requesting and the limit enabled: 3×(`MAX_HOLD`+1) cycles.
- `gnt`, `gnt_idx` and `gnt_valid` change only on clock edges or on async reset. They are glitch-free to downstream logic.

## Test plan
- **Reset and first grant.** Release `rst_n`, hold `en`=1, `req`=4'b1111.
  - Expect `gnt`=4'b0001 and `gnt_idx`=0 one cycle later.
  - Pulse `rel` after each grant: grant order is 0,1,2,3,0 with one idle cycle between grants.
- **Single requester.** `req`=4'b0100 from IDLE.
  - Expect `gnt`=4'b0100 and `gnt_idx`=2 the next cycle.
  - Drop `req[2]`: `gnt`=0 after one edge, `timeout`=0.
- **Hold limit.** `MAX_HOLD`=4, `req`=4'b0011, `rel` never asserted.
  - Requester 0 is granted for exactly 4 cycles.
  - `timeout` pulses for 1 cycle, one idle cycle follows, then `gnt`=4'b0010.
- **Enable drop.** Mid-grant of requester 1, set `en`=0.
  - `gnt`=0 after the next edge, `timeout`=0.
  - No grant is issued while `en`=0 even with `req`=4'b1111.
  - After re-enable, requester 2 is granted first.
- **Simultaneous release and limit.** `MAX_HOLD`=2; assert `rel` in the cycle where `hold_cnt`=1.
  - Grant ends with `timeout`=0.
- **Async reset mid-grant.** Pull `rst_n` low between edges while `gnt`=4'b1000.
  - All outputs read 0 immediately.
  - After reset, with `req`=4'b1111, requester 0 is granted first.
